// File: rtl/mux_bin_pkg.sv
// rtl/mux_bin_pkg.sv - select-slice and stage-size helpers for mux_bin_pipe
package mux_bin_pkg;

  function automatic int width_log(input int width);
    return $clog2(width);
  endfunction

  function automatic int split_log(input int split);
    return $clog2(split);
  endfunction

  function automatic int stage_cnt(input int width, input int split);
    return (width_log(width) + split_log(split) - 1) / split_log(split);
  endfunction

  // Lowest select bit consumed by stage k; slices go LSB group first.
  function automatic int sel_lo(input int split, input int k);
    return k * split_log(split);
  endfunction

  function automatic int sel_bits(input int width, input int split, input int k);
    int hi;
    hi = (k + 1) * split_log(split);
    if (hi > width_log(width)) hi = width_log(width);
    return hi - sel_lo(split, k);
  endfunction

  function automatic int ary_out(input int width, input int split, input int k);
    return width >> (sel_lo(split, k) + sel_bits(width, split, k));
  endfunction

endpackage

// File: rtl/mux_bin_stage.sv
// rtl/mux_bin_stage.sv - one registered reduction stage of mux_bin_pipe
module mux_bin_stage #(
  parameter type DAT_T    = logic [7:0],
  parameter int  IN_N     = 16,
  parameter int  SEL_W    = 2,
  parameter int  IN_SEL_W = 4,
  parameter int  OUT_N    = IN_N >> SEL_W,
  parameter int  REM_W    = (IN_SEL_W > SEL_W) ? IN_SEL_W - SEL_W : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_vld,
  output logic                o_rdy,
  input  DAT_T                i_ary [IN_N],
  input  logic [IN_SEL_W-1:0] i_sel,
  output logic                o_vld,
  input  logic                i_rdy,
  output DAT_T                o_ary [OUT_N],
  output logic [REM_W-1:0]    o_sel
);
  localparam int WAYS  = 1 << SEL_W;
  localparam int IDX_W = $clog2(IN_N);

  logic             r_vld;
  DAT_T             r_ary [OUT_N];
  logic [REM_W-1:0] r_sel;
  DAT_T             w_pick [OUT_N];
  logic [REM_W-1:0] w_rem;
  logic [SEL_W-1:0] w_slot;

  assign w_slot = i_sel[SEL_W-1:0];

  // The final stage has no upper select bits left to carry.
  if (IN_SEL_W > SEL_W) begin : g_rem
    assign w_rem = i_sel[IN_SEL_W-1:SEL_W];
  end else begin : g_norem
    assign w_rem = '0;
  end

  always_comb begin
    for (int j = 0; j < OUT_N; j++) begin
      w_pick[j] = i_ary[IDX_W'(j * WAYS + int'(w_slot))];
    end
  end

  assign o_rdy = !r_vld || i_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= 1'b0;
      r_sel <= '0;
      for (int j = 0; j < OUT_N; j++) r_ary[j] <= '0;
    end else if (o_rdy) begin
      r_vld <= i_vld;
      if (i_vld) begin
        r_ary <= w_pick;
        r_sel <= w_rem;
      end
    end
  end

  assign o_vld = r_vld;
  assign o_ary = r_ary;
  assign o_sel = r_sel;

endmodule

// File: rtl/mux_bin_pipe.sv
// rtl/mux_bin_pipe.sv - pipelined binary-select array mux with valid/ready stages
// MUX_BIN_PIPE_LOCK_EN: hold the first beat's select until the src_lst beat is accepted.
module mux_bin_pipe
  import mux_bin_pkg::*;
#(
  parameter type DAT_T = logic [7:0],
  parameter int  WIDTH = 16,
  parameter int  SPLIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     src_vld,
  output logic                     src_rdy,
  input  logic [$clog2(WIDTH)-1:0] src_bin,
  input  DAT_T                     src_ary [WIDTH],
  input  logic                     src_lst,
  output logic                     dst_vld,
  input  logic                     dst_rdy,
  output DAT_T                     dst_dat
);
  localparam int WL     = width_log(WIDTH);
  localparam int STAGES = stage_cnt(WIDTH, SPLIT);

  logic [WL-1:0] w_bin;

`ifdef MUX_BIN_PIPE_LOCK_EN
  logic          r_open;
  logic [WL-1:0] r_bin;
  logic          w_acc;

  assign w_acc = src_vld && src_rdy;
  assign w_bin = r_open ? r_bin : src_bin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_open <= 1'b0;
      r_bin  <= '0;
    end else if (w_acc) begin
      r_open <= !src_lst;
      if (!r_open) r_bin <= src_bin;
    end
  end
`else
  logic w_unused_lst;
  assign w_unused_lst = src_lst;
  assign w_bin        = src_bin;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO    = sel_lo(SPLIT, k);
    localparam int SB    = sel_bits(WIDTH, SPLIT, k);
    localparam int IN_N  = WIDTH >> LO;
    localparam int OUT_N = ary_out(WIDTH, SPLIT, k);
    localparam int ISW   = WL - LO;
    localparam int RW    = (ISW > SB) ? ISW - SB : 1;

    logic           w_vld_in, w_rdy, w_vld, w_nxt_rdy;
    DAT_T           w_in  [IN_N];
    DAT_T           w_out [OUT_N];
    logic [ISW-1:0] w_sel_in;
    logic [RW-1:0]  w_sel_out;

    if (k == 0) begin : g_first
      assign w_vld_in = src_vld;
      assign w_in     = src_ary;
      assign w_sel_in = w_bin;
    end else begin : g_mid
      assign w_vld_in = g_stage[k-1].w_vld;
      assign w_in     = g_stage[k-1].w_out;
      assign w_sel_in = g_stage[k-1].w_sel_out;
    end

    if (k == STAGES - 1) begin : g_last
      logic w_unused;
      assign w_nxt_rdy = dst_rdy;
      assign w_unused  = ^w_sel_out;
    end else begin : g_inner
      assign w_nxt_rdy = g_stage[k+1].w_rdy;
    end

    mux_bin_stage #(
      .DAT_T    (DAT_T),
      .IN_N     (IN_N),
      .SEL_W    (SB),
      .IN_SEL_W (ISW)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .i_vld (w_vld_in),
      .o_rdy (w_rdy),
      .i_ary (w_in),
      .i_sel (w_sel_in),
      .o_vld (w_vld),
      .i_rdy (w_nxt_rdy),
      .o_ary (w_out),
      .o_sel (w_sel_out)
    );
  end

  assign src_rdy = g_stage[0].w_rdy;
  assign dst_vld = g_stage[STAGES-1].w_vld;
  assign dst_dat = g_stage[STAGES-1].w_out[0];

endmodule
